// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the fault-tolerance error monitor.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    FT_MON_IDLE   = 2'd0,
    FT_MON_REPORT = 2'd1,
    FT_MON_FATAL  = 2'd2
  } ft_mon_state_e;

  localparam int unsigned FT_REPLICA_A = 0;
  localparam int unsigned FT_REPLICA_B = 1;
  localparam int unsigned FT_REPLICA_C = 2;

endpackage

// File: rtl/cv32e40p_ft_replica_tracker.sv
// Per-replica mismatch tally: saturating total count, consecutive-hit run, sticky faulty bit.
module cv32e40p_ft_replica_tracker #(
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned PERM_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hit,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 faulty
);

  localparam int unsigned CONSEC_W = $clog2(PERM_THRESH + 1);

  logic [CONSEC_W-1:0] consec_q;
  logic                consec_full;

  assign consec_full = (consec_q == CONSEC_W'(PERM_THRESH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      consec_q <= '0;
      faulty   <= 1'b0;
    end else if (clear) begin
      cnt      <= '0;
      consec_q <= '0;
      faulty   <= 1'b0;
    end else begin
      if (hit && (cnt != '1)) cnt <= cnt + CNT_WIDTH'(1);
      if (!hit)              consec_q <= '0;
      else if (!consec_full) consec_q <= consec_q + CONSEC_W'(1);
      // Faulty trails the run reaching threshold by one cycle.
      if (consec_full) faulty <= 1'b1;
    end
  end

endmodule

// File: rtl/cv32e40p_ft_error_monitor.sv
// Watches TMR voter disagreement flags, tracks per-replica faults and posts error events.
module cv32e40p_ft_error_monitor
  import cv32e40p_pkg::*;
#(
  parameter int unsigned NUM_VOTERS  = 4,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned PERM_THRESH = 4,
  localparam int unsigned VOTER_W    = $clog2(NUM_VOTERS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_VOTERS-1:0] err_a_i,
  input  logic [NUM_VOTERS-1:0] err_b_i,
  input  logic [NUM_VOTERS-1:0] err_c_i,
  input  logic                  clear_i,
  output logic [CNT_WIDTH-1:0]  err_cnt_a_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_b_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_c_o,
  output logic [2:0]            faulty_o,
  output logic                  uncorrectable_o,
  output logic                  overflow_o,
  output logic                  event_valid_o,
  input  logic                  event_ready_i,
  output logic [VOTER_W-1:0]    event_voter_o,
  output logic [2:0]            event_mask_o
);

  ft_mon_state_e state_q, state_d;

  logic               hit_a, hit_b, hit_c, any_hit;
  logic               triple, multi_faulty;
  logic [VOTER_W-1:0] enc_voter;
  logic [2:0]         enc_mask;
  logic               valid_d, overflow_d;
  logic [VOTER_W-1:0] voter_d;
  logic [2:0]         mask_d;

  assign hit_a   = |err_a_i;
  assign hit_b   = |err_b_i;
  assign hit_c   = |err_c_i;
  assign any_hit = hit_a | hit_b | hit_c;
  assign triple  = |(err_a_i & err_b_i & err_c_i);
  assign multi_faulty = (faulty_o[0] & faulty_o[1]) | (faulty_o[0] & faulty_o[2]) |
                        (faulty_o[1] & faulty_o[2]);

  cv32e40p_ft_replica_tracker #(.CNT_WIDTH(CNT_WIDTH), .PERM_THRESH(PERM_THRESH)) u_trk_a (
    .clk(clk), .rst_n(rst_n), .hit(hit_a), .clear(clear_i),
    .cnt(err_cnt_a_o), .faulty(faulty_o[FT_REPLICA_A])
  );
  cv32e40p_ft_replica_tracker #(.CNT_WIDTH(CNT_WIDTH), .PERM_THRESH(PERM_THRESH)) u_trk_b (
    .clk(clk), .rst_n(rst_n), .hit(hit_b), .clear(clear_i),
    .cnt(err_cnt_b_o), .faulty(faulty_o[FT_REPLICA_B])
  );
  cv32e40p_ft_replica_tracker #(.CNT_WIDTH(CNT_WIDTH), .PERM_THRESH(PERM_THRESH)) u_trk_c (
    .clk(clk), .rst_n(rst_n), .hit(hit_c), .clear(clear_i),
    .cnt(err_cnt_c_o), .faulty(faulty_o[FT_REPLICA_C])
  );

  // Lowest flagged voter wins: scan from the top so the smallest index is written last.
  always_comb begin
    enc_voter = '0;
    enc_mask  = '0;
    for (int k = NUM_VOTERS - 1; k >= 0; k--) begin
      if (err_a_i[k] | err_b_i[k] | err_c_i[k]) begin
        enc_voter = VOTER_W'(k);
        enc_mask  = {err_c_i[k], err_b_i[k], err_a_i[k]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= FT_MON_IDLE;
      event_valid_o   <= 1'b0;
      event_voter_o   <= '0;
      event_mask_o    <= '0;
      overflow_o      <= 1'b0;
      uncorrectable_o <= 1'b0;
    end else begin
      state_q         <= state_d;
      event_valid_o   <= valid_d;
      event_voter_o   <= voter_d;
      event_mask_o    <= mask_d;
      overflow_o      <= overflow_d;
      uncorrectable_o <= clear_i ? 1'b0 : (uncorrectable_o | triple | multi_faulty);
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = event_valid_o;
    voter_d    = event_voter_o;
    mask_d     = event_mask_o;
    overflow_d = overflow_o;

    unique case (state_q)
      FT_MON_IDLE: begin
        if (any_hit) begin
          state_d = FT_MON_REPORT;
          valid_d = 1'b1;
          voter_d = enc_voter;
          mask_d  = enc_mask;
        end
      end
      FT_MON_REPORT: begin
        if (event_ready_i) begin
          if (any_hit) begin
            voter_d = enc_voter;
            mask_d  = enc_mask;
          end else begin
            state_d = FT_MON_IDLE;
            valid_d = 1'b0;
          end
        end else if (any_hit) begin
          overflow_d = 1'b1;
        end
      end
      FT_MON_FATAL: begin
        valid_d = 1'b1;
        mask_d  = 3'b111;
      end
      default: state_d = FT_MON_IDLE;
    endcase

    if (uncorrectable_o && (state_q != FT_MON_FATAL)) begin
      state_d = FT_MON_FATAL;
      valid_d = 1'b1;
      mask_d  = 3'b111;
    end

    if (clear_i) begin
      state_d    = FT_MON_IDLE;
      valid_d    = 1'b0;
      voter_d    = '0;
      mask_d     = '0;
      overflow_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_cv32e40p_ft_error_monitor.sv
// Directed self-checking bench for the fault-tolerance error monitor.
module tb_cv32e40p_ft_error_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] err_a, err_b, err_c;
  logic       clear, ready;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [2:0] faulty, ev_mask;
  logic       uncorr, ovf, ev_valid;
  logic [1:0] ev_voter;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cv32e40p_ft_error_monitor #(.NUM_VOTERS(4), .CNT_WIDTH(8), .PERM_THRESH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .err_a_i(err_a), .err_b_i(err_b), .err_c_i(err_c),
    .clear_i(clear),
    .err_cnt_a_o(cnt_a), .err_cnt_b_o(cnt_b), .err_cnt_c_o(cnt_c),
    .faulty_o(faulty), .uncorrectable_o(uncorr), .overflow_o(ovf),
    .event_valid_o(ev_valid), .event_ready_i(ready),
    .event_voter_o(ev_voter), .event_mask_o(ev_mask)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; returns 1 time unit after the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    err_a = '0; err_b = '0; err_c = '0;
    clear = 1'b0; ready = 1'b0;
    #12;
    check("rst_cnt_a", 32'(cnt_a), 0);
    check("rst_valid", 32'(ev_valid), 0);
    check("rst_flags", 32'({faulty, uncorr, ovf}), 0);
    check("rst_event", 32'({ev_voter, ev_mask}), 0);
    rst_n = 1'b1;
    step(1);

    // Single-voter single-cycle fault
    err_b = 4'b0100;
    step(1);
    err_b = '0;
    check("t1_cnt_b", 32'(cnt_b), 1);
    check("t1_valid", 32'(ev_valid), 1);
    check("t1_voter", 32'(ev_voter), 2);
    check("t1_mask", 32'(ev_mask), 3'b010);
    check("t1_faulty", 32'(faulty), 0);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("t1_ack", 32'(ev_valid), 0);

    // Persistent fault on A, then same with a gap
    do_clear();
    err_a = 4'b0001;
    step(4);
    err_a = '0;
    check("t2_faulty_lag", 32'(faulty), 0);
    check("t2_cnt_a", 32'(cnt_a), 4);
    step(1);
    check("t2_faulty", 32'(faulty), 3'b001);
    do_clear();
    err_a = 4'b0001;
    step(3);
    err_a = '0;
    step(1);
    err_a = 4'b0001;
    step(1);
    err_a = '0;
    step(1);
    check("t2_gap_faulty", 32'(faulty), 0);
    check("t2_gap_cnt_a", 32'(cnt_a), 4);

    // Backpressure and overflow
    do_clear();
    err_a = 4'b0010;
    step(1);
    err_a = '0;
    err_c = 4'b1000;
    step(1);
    err_c = '0;
    check("t3_valid", 32'(ev_valid), 1);
    check("t3_held", 32'({ev_voter, ev_mask}), {2'd1, 3'b001});
    check("t3_ovf", 32'(ovf), 1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("t3_ack", 32'(ev_valid), 0);
    step(1);
    check("t3_idle", 32'(ev_valid), 0);

    // Triple disagreement goes fatal
    do_clear();
    err_a = 4'b0010; err_b = 4'b0010; err_c = 4'b0010;
    step(1);
    err_a = '0; err_b = '0; err_c = '0;
    check("t4_uncorr", 32'(uncorr), 1);
    ready = 1'b1;
    step(1);
    check("t4_fatal", 32'({ev_valid, ev_mask}), {1'b1, 3'b111});
    step(1);
    check("t4_fatal_hold", 32'({ev_valid, ev_mask}), {1'b1, 3'b111});
    ready = 1'b0;
    do_clear();
    check("t4_clr_flags", 32'({faulty, uncorr, ovf}), 0);
    check("t4_clr_event", 32'({ev_valid, ev_voter, ev_mask}), 0);
    check("t4_clr_cnts", 32'({cnt_a, cnt_b, cnt_c}), 0);

    // Saturation on C
    ready = 1'b1;
    err_c = 4'b0001;
    step(300);
    err_c = '0;
    check("t5_cnt_c", 32'(cnt_c), 255);
    check("t5_faulty", 32'(faulty), 3'b100);
    check("t5_uncorr", 32'(uncorr), 0);
    check("t5_ovf", 32'(ovf), 0);
    step(1);
    ready = 1'b0;
    do_clear();

    // Clear beats a same-cycle hit; async reset mid-report
    err_a = 4'b0001;
    step(1);
    err_a = '0;
    clear = 1'b1;
    err_a = 4'b0001;
    step(1);
    clear = 1'b0;
    err_a = '0;
    check("t6_clr_cnt_a", 32'(cnt_a), 0);
    check("t6_clr_valid", 32'(ev_valid), 0);
    err_a = 4'b1000;
    step(1);
    err_a = '0;
    check("t6_report", 32'({ev_valid, ev_voter}), {1'b1, 2'd3});
    rst_n = 1'b0;
    #1;
    check("t6_rst_event", 32'({ev_valid, ev_voter, ev_mask}), 0);
    check("t6_rst_cnt_a", 32'(cnt_a), 0);
    #2;
    rst_n = 1'b1;
    step(1);
    check("t6_post_rst", 32'(ev_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
